// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES host-side I/O sequencer.
package aes_io_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_LOAD,
    ST_DATA_LOAD,
    ST_RUN,
    ST_READ,
    ST_RELEASE
  } aio_state_e;

  // Key-size encodings on the mode bus
  localparam logic [1:0] MODE_128     = 2'b00;
  localparam logic [1:0] MODE_128_ALT = 2'b01;
  localparam logic [1:0] MODE_192     = 2'b10;
  localparam logic [1:0] MODE_256     = 2'b11;

  // One AES block is four 32-bit words in and four out
  localparam logic [3:0] BLOCK_WORDS = 4'd4;

  // Number of key words (NK) for a given mode
  function automatic logic [3:0] key_words(input logic [1:0] mode);
    case (mode)
      MODE_128, MODE_128_ALT: key_words = 4'd4;
      MODE_192:               key_words = 4'd6;
      MODE_256:               key_words = 4'd8;
      default:                key_words = 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/aes_io_out_stage.sv
// One-entry valid/ready holding register for the result word stream.
// A load always wins; the sequencer never loads while a word is still held.
module aes_io_out_stage
  import aes_io_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] ld_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  // Hold the word until the host takes it; data only changes on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ld) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_io_sequencer.sv
// Host-side load/unload sequencer for the AES control unit: writes key and
// data words into the core memories, raises start, then reads the four
// result words back and streams them to the host before releasing start.
module aes_io_sequencer
  import aes_io_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          AIO_I_CLK,
  input  logic          AIO_I_RST,
  input  logic          AIO_I_CFG_VALID,
  input  logic [1:0]    AIO_I_CFG_MODE,
  input  logic          AIO_I_CFG_E_D,
  input  logic          AIO_I_IN_VALID,
  input  logic [DW-1:0] AIO_I_IN_DATA,
  output logic          AIO_O_IN_READY,
  output logic          AIO_O_OUT_VALID,
  output logic [DW-1:0] AIO_O_OUT_DATA,
  input  logic          AIO_I_OUT_READY,
  output logic [1:0]    AIO_O_AES_MODE,
  output logic          AIO_O_E_D,
  output logic          AIO_O_D_K,
  output logic [3:0]    AIO_O_COUNT_IO,
  output logic          AIO_O_KEY_LD_WAIT,
  output logic          AIO_O_DATA_LD_WAIT,
  output logic          AIO_O_START,
  input  logic          AIO_I_DATA_DONE,
  output logic          AIO_O_KEY_WE,
  output logic          AIO_O_DATA_WE,
  output logic [2:0]    AIO_O_WADDR,
  output logic [DW-1:0] AIO_O_WDATA,
  output logic          AIO_O_RE,
  output logic [1:0]    AIO_O_RADDR,
  input  logic [DW-1:0] AIO_I_RDATA
);

  aio_state_e    state_q, state_d;

  logic [1:0]    mode_q;
  logic          e_d_q;
  logic          d_k_q;
  logic [3:0]    count_q;
  logic          in_ready_q;
  logic          key_ld_wait_q;
  logic          data_ld_wait_q;
  logic          start_q;
  logic          key_we_q;
  logic          data_we_q;
  logic [2:0]    waddr_q;
  logic [DW-1:0] wdata_q;
  logic          re_q;
  logic [1:0]    raddr_q;
  logic          rd_vld_q;   // RDATA is valid this cycle (RE delayed by one)

  logic          out_valid;
  logic [DW-1:0] out_data;

  logic [3:0]    nk;
  logic          accept;
  logic          out_accept;

  assign nk         = key_words(mode_q);
  assign accept     = AIO_I_IN_VALID && in_ready_q;
  assign out_accept = out_valid && AIO_I_OUT_READY;

  // State register
  always_ff @(posedge AIO_I_CLK or posedge AIO_I_RST) begin
    if (AIO_I_RST) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode; raddr_q doubles as the readout word index
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (AIO_I_CFG_VALID)               state_d = ST_KEY_LOAD;
      ST_KEY_LOAD:  if (count_q == nk)                 state_d = ST_DATA_LOAD;
      ST_DATA_LOAD: if (count_q == BLOCK_WORDS)        state_d = ST_RUN;
      ST_RUN:       if (AIO_I_DATA_DONE)               state_d = ST_READ;
      ST_READ:      if (out_accept && raddr_q == 2'd3) state_d = ST_RELEASE;
      ST_RELEASE:   if (!AIO_I_DATA_DONE)              state_d = ST_DATA_LOAD;
      default:                                         state_d = ST_IDLE;
    endcase
  end

  // Registered handshake, memory-port and status outputs.
  // IN_READY drops on the edge that takes the last word of a phase, so the
  // phase-complete branch (count == limit) never coincides with an accept.
  always_ff @(posedge AIO_I_CLK or posedge AIO_I_RST) begin
    if (AIO_I_RST) begin
      mode_q         <= 2'b00;
      e_d_q          <= 1'b0;
      d_k_q          <= 1'b0;
      count_q        <= 4'd0;
      in_ready_q     <= 1'b0;
      key_ld_wait_q  <= 1'b1;
      data_ld_wait_q <= 1'b1;
      start_q        <= 1'b0;
      key_we_q       <= 1'b0;
      data_we_q      <= 1'b0;
      waddr_q        <= 3'd0;
      wdata_q        <= '0;
      re_q           <= 1'b0;
      raddr_q        <= 2'd0;
      rd_vld_q       <= 1'b0;
    end else begin
      key_we_q  <= 1'b0;
      data_we_q <= 1'b0;
      re_q      <= 1'b0;
      rd_vld_q  <= re_q;
      case (state_q)
        ST_IDLE: begin
          if (AIO_I_CFG_VALID) begin
            mode_q     <= AIO_I_CFG_MODE;
            e_d_q      <= AIO_I_CFG_E_D;
            in_ready_q <= 1'b1;
          end
        end
        ST_KEY_LOAD: begin
          if (count_q == nk) begin
            key_ld_wait_q  <= 1'b0;
            d_k_q          <= 1'b1;
            count_q        <= 4'd0;
            data_ld_wait_q <= 1'b1;
            in_ready_q     <= 1'b1;
          end else if (accept) begin
            key_we_q <= 1'b1;
            waddr_q  <= count_q[2:0];
            wdata_q  <= AIO_I_IN_DATA;
            count_q  <= count_q + 4'd1;
            if (count_q + 4'd1 == nk) in_ready_q <= 1'b0;
          end
        end
        ST_DATA_LOAD: begin
          if (count_q == BLOCK_WORDS) begin
            data_ld_wait_q <= 1'b0;
            start_q        <= 1'b1;
          end else if (accept) begin
            data_we_q <= 1'b1;
            waddr_q   <= count_q[2:0];
            wdata_q   <= AIO_I_IN_DATA;
            count_q   <= count_q + 4'd1;
            if (count_q + 4'd1 == BLOCK_WORDS) in_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (AIO_I_DATA_DONE) begin
            re_q    <= 1'b1;
            raddr_q <= 2'd0;
          end
        end
        ST_READ: begin
          // Next read only once the held word has gone to the host
          if (out_accept) begin
            if (raddr_q != 2'd3) begin
              re_q    <= 1'b1;
              raddr_q <= raddr_q + 2'd1;
            end else begin
              start_q <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          // Control unit has dropped done: reopen the data phase, key kept
          if (!AIO_I_DATA_DONE) begin
            count_q        <= 4'd0;
            data_ld_wait_q <= 1'b1;
            in_ready_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  aes_io_out_stage #(.DW(DW)) u_out_stage (
    .clk       (AIO_I_CLK),
    .rst       (AIO_I_RST),
    .ld        (rd_vld_q),
    .ld_data   (AIO_I_RDATA),
    .out_ready (AIO_I_OUT_READY),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign AIO_O_IN_READY     = in_ready_q;
  assign AIO_O_OUT_VALID    = out_valid;
  assign AIO_O_OUT_DATA     = out_data;
  assign AIO_O_AES_MODE     = mode_q;
  assign AIO_O_E_D          = e_d_q;
  assign AIO_O_D_K          = d_k_q;
  assign AIO_O_COUNT_IO     = count_q;
  assign AIO_O_KEY_LD_WAIT  = key_ld_wait_q;
  assign AIO_O_DATA_LD_WAIT = data_ld_wait_q;
  assign AIO_O_START        = start_q;
  assign AIO_O_KEY_WE       = key_we_q;
  assign AIO_O_DATA_WE      = data_we_q;
  assign AIO_O_WADDR        = waddr_q;
  assign AIO_O_WDATA        = wdata_q;
  assign AIO_O_RE           = re_q;
  assign AIO_O_RADDR        = raddr_q;

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Scoreboard bench for aes_io_sequencer: expected memory writes and result
// words are queued as stimulus is driven and compared as the DUT produces them.
module tb_aes_io_sequencer;
  localparam int DW = 32;
  typedef logic [35:0] wr_t;   // {data_not_key, waddr, wdata}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_mode = 2'b00;
  logic          cfg_e_d = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    aes_mode;
  logic          e_d, d_k;
  logic [3:0]    count_io;
  logic          key_ld_wait, data_ld_wait, start;
  logic          data_done = 1'b0;
  logic          key_we, data_we;
  logic [2:0]    waddr;
  logic [DW-1:0] wdata;
  logic          re;
  logic [1:0]    raddr;
  logic [DW-1:0] rdata = '0;

  int total = 0;
  int passed = 0;

  wr_t           obs_wr[$];
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_out[$];
  int            n_re = 0;
  logic [DW-1:0] rmem [4];

  always #5 clk = ~clk;

  aes_io_sequencer #(.DW(DW)) dut (
    .AIO_I_CLK(clk), .AIO_I_RST(rst),
    .AIO_I_CFG_VALID(cfg_valid), .AIO_I_CFG_MODE(cfg_mode), .AIO_I_CFG_E_D(cfg_e_d),
    .AIO_I_IN_VALID(in_valid), .AIO_I_IN_DATA(in_data), .AIO_O_IN_READY(in_ready),
    .AIO_O_OUT_VALID(out_valid), .AIO_O_OUT_DATA(out_data), .AIO_I_OUT_READY(out_ready),
    .AIO_O_AES_MODE(aes_mode), .AIO_O_E_D(e_d), .AIO_O_D_K(d_k), .AIO_O_COUNT_IO(count_io),
    .AIO_O_KEY_LD_WAIT(key_ld_wait), .AIO_O_DATA_LD_WAIT(data_ld_wait), .AIO_O_START(start),
    .AIO_I_DATA_DONE(data_done), .AIO_O_KEY_WE(key_we), .AIO_O_DATA_WE(data_we),
    .AIO_O_WADDR(waddr), .AIO_O_WDATA(wdata), .AIO_O_RE(re), .AIO_O_RADDR(raddr),
    .AIO_I_RDATA(rdata)
  );

  // State memory model: one-cycle read latency
  always @(posedge clk) if (re) rdata <= rmem[raddr];

  // Write and read-strobe monitor (append-only log)
  always @(negedge clk) begin
    if (key_we)  obs_wr.push_back({1'b0, waddr, wdata});
    if (data_we) obs_wr.push_back({1'b1, waddr, wdata});
    if (re)      n_re++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_e_d = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; data_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_cfg(input logic [1:0] m, input logic ed);
    cfg_valid = 1'b1; cfg_mode = m; cfg_e_d = ed;
    tick();
    cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_e_d = 1'b0;
  endtask

  // Present one word until accepted; queue the write it must produce
  task automatic send_word(input logic kind, input logic [2:0] idx, input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    exp_wr.push_back({kind, idx, w});
    in_valid = 1'b1; in_data = w;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk); ok = in_ready;
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    if (!ok) begin total++; $display("FAIL send_timeout: word %h not accepted, required accept", w); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if ({in_ready, out_valid, d_k, start, key_we, data_we, re} !== 7'b0)
      $display("FAIL rst_ctl: got %b exp 0000000", {in_ready, out_valid, d_k, start, key_we, data_we, re}); else passed++;
    total++; if ({key_ld_wait, data_ld_wait} !== 2'b11)
      $display("FAIL rst_ldwait: got %b exp 11", {key_ld_wait, data_ld_wait}); else passed++;
    total++; if ({count_io, waddr, raddr, aes_mode, e_d} !== 12'd0)
      $display("FAIL rst_regs: got %h exp 0", {count_io, waddr, raddr, aes_mode, e_d}); else passed++;
    total++; if ({out_data, wdata} !== '0)
      $display("FAIL rst_data: got %h exp 0", {out_data, wdata}); else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mode00();
    int wb;
    do_reset();
    wb = obs_wr.size();
    do_cfg(2'b00, 1'b1);
    @(negedge clk);
    total++; if ({aes_mode, e_d, in_ready, key_ld_wait} !== 5'b00111)
      $display("FAIL m00_cfg: got %b exp 00111", {aes_mode, e_d, in_ready, key_ld_wait}); else passed++;
    tick();
    for (int i = 0; i < 4; i++) send_word(1'b0, 3'(i), 32'h1000_0000 + i);
    @(negedge clk);
    total++; if ({key_we, key_ld_wait, in_ready, count_io} !== 7'b110_0100)
      $display("FAIL m00_key_last: got %b exp 1100100", {key_we, key_ld_wait, in_ready, count_io}); else passed++;
    @(negedge clk);
    total++; if ({key_ld_wait, d_k, in_ready, count_io} !== 7'b011_0000)
      $display("FAIL m00_key_done: got %b exp 0110000", {key_ld_wait, d_k, in_ready, count_io}); else passed++;
    tick();
    for (int i = 0; i < 4; i++) send_word(1'b1, 3'(i), 32'h2000_0000 + i);
    @(negedge clk);
    total++; if ({start, data_ld_wait, data_we} !== 3'b011)
      $display("FAIL m00_data_last: got %b exp 011", {start, data_ld_wait, data_we}); else passed++;
    @(negedge clk);
    total++; if ({start, data_ld_wait, d_k, count_io} !== 7'b101_0100)
      $display("FAIL m00_start: got %b exp 1010100", {start, data_ld_wait, d_k, count_io}); else passed++;
    tick();
    total++; if (obs_wr.size() - wb != exp_wr.size())
      $display("FAIL m00_wr_count: got %0d exp %0d", obs_wr.size() - wb, exp_wr.size()); else passed++;
    for (int i = 0; exp_wr.size() > 0; i++) begin
      wr_t e = exp_wr.pop_front();
      total++; if (obs_wr[wb+i] !== e) $display("FAIL m00_wr%0d: got %h exp %h", i, obs_wr[wb+i], e); else passed++;
    end
  endtask

  // Continues from test_mode00 (block loaded, START high)
  task automatic test_readout_stall();
    int rb;
    bit got;
    rmem[0] = 32'h0011_2233; rmem[1] = 32'h4455_6677;
    rmem[2] = 32'h8899_AABB; rmem[3] = 32'hCCDD_EEFF;
    for (int i = 0; i < 4; i++) exp_out.push_back(rmem[i]);
    rb = n_re;
    data_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (out_valid) begin got = 1'b1; break; end
      end
      if (!got) begin total++; $display("FAIL rd_timeout: word %0d, out_valid 0, required 1", k); end
      total++; if (out_data !== exp_out[0]) $display("FAIL rd_stall%0d_a: got %h exp %h", k, out_data, exp_out[0]); else passed++;
      for (int s = 0; s < 2; s++) begin
        tick(); @(negedge clk);
        total++; if ({out_valid, out_data} !== {1'b1, exp_out[0]})
          $display("FAIL rd_stall%0d_b: got %b/%h exp 1/%h", k, out_valid, out_data, exp_out[0]); else passed++;
      end
      total++; if (n_re - rb != k + 1) $display("FAIL rd_re_hold%0d: got %0d exp %0d", k, n_re - rb, k + 1); else passed++;
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      total++; if ({out_valid, start, out_data} !== {2'b11, exp_out[0]})
        $display("FAIL rd_word%0d: got %b%b/%h exp 11/%h", k, out_valid, start, out_data, exp_out[0]); else passed++;
      void'(exp_out.pop_front());
      tick();
      out_ready = 1'b0;
    end
    @(negedge clk);
    total++; if ({start, out_valid} !== 2'b00) $display("FAIL rd_release: got %b exp 00", {start, out_valid}); else passed++;
    total++; if (n_re - rb != 4) $display("FAIL rd_re_count: got %0d exp 4", n_re - rb); else passed++;
    tick();
    data_done = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    total++; if ({got, d_k, count_io, data_ld_wait} !== 7'b110_0001)
      $display("FAIL rd_next_block: got %b exp 1100001", {got, d_k, count_io, data_ld_wait}); else passed++;
    tick();
  endtask

  task automatic test_mode11_toggle();
    int wb, i;
    logic [3:0] n;
    do_reset();
    wb = obs_wr.size();
    do_cfg(2'b11, 1'b0);
    n = 4'd0; i = 0;
    while (n < 4'd8 && i < 60) begin
      in_valid = (i % 2 == 0); in_data = 32'hA000_0000 + 32'(n);
      @(negedge clk);
      if (in_valid && in_ready) begin exp_wr.push_back({1'b0, n[2:0], in_data}); n++; end
      tick(); i++;
    end
    if (n != 4'd8) begin total++; $display("FAIL m11_timeout: accepted %0d, required 8", n); end
    in_valid = 1'b1; in_data = 32'hA000_0008;
    @(negedge clk);
    total++; if ({in_ready, key_we, count_io} !== 6'b01_1000)
      $display("FAIL m11_ninth: got %b exp 011000", {in_ready, key_we, count_io}); else passed++;
    tick();
    in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    total++; if ({key_ld_wait, d_k, count_io} !== 6'b01_0000)
      $display("FAIL m11_done: got %b exp 010000", {key_ld_wait, d_k, count_io}); else passed++;
    total++; if (obs_wr.size() - wb != exp_wr.size())
      $display("FAIL m11_wr_count: got %0d exp %0d", obs_wr.size() - wb, exp_wr.size()); else passed++;
    for (int j = 0; exp_wr.size() > 0; j++) begin
      wr_t e = exp_wr.pop_front();
      total++; if (obs_wr[wb+j] !== e) $display("FAIL m11_wr%0d: got %h exp %h", j, obs_wr[wb+j], e); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int wb, first, last, cyc, got;
    bit ok;
    do_reset();
    wb = obs_wr.size();
    do_cfg(2'b10, 1'b1);
    for (int i = 0; i < 6; i++) send_word(1'b0, 3'(i), 32'hB000_0000 + i);
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 4; i++) send_word(1'b1, 3'(i), 32'hD000_0000 + 32'(blk * 16 + i));
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (start) begin ok = 1'b1; break; end
      end
      total++; if ({ok, aes_mode, d_k} !== 4'b1101)
        $display("FAIL b2b_start%0d: got %b exp 1101", blk, {ok, aes_mode, d_k}); else passed++;
      total++; if (obs_wr.size() - wb != exp_wr.size())
        $display("FAIL b2b_wr_count%0d: got %0d exp %0d", blk, obs_wr.size() - wb, exp_wr.size()); else passed++;
      for (int j = 0; exp_wr.size() > 0; j++) begin
        wr_t e = exp_wr.pop_front();
        total++; if (obs_wr[wb+j] !== e) $display("FAIL b2b_wr%0d_%0d: got %h exp %h", blk, j, obs_wr[wb+j], e); else passed++;
      end
      wb = obs_wr.size();
      tick();
      for (int i = 0; i < 4; i++) begin
        rmem[i] = 32'hE000_0000 + 32'(blk * 256 + i * 17);
        exp_out.push_back(rmem[i]);
      end
      data_done = 1'b1; out_ready = 1'b1;
      first = -1; last = -1; got = 0;
      for (cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        if (re && first < 0) first = cyc;
        if (out_valid) begin
          logic [DW-1:0] e = exp_out.pop_front();
          total++; if (out_data !== e) $display("FAIL b2b_out%0d_%0d: got %h exp %h", blk, got, out_data, e); else passed++;
          got++;
          if (got == 4) last = cyc;
        end
      end
      total++; if (last - first + 1 != 12)
        $display("FAIL b2b_latency%0d: got %0d cycles exp 12", blk, last - first + 1); else passed++;
      tick();
      out_ready = 1'b0; data_done = 1'b0;
      @(negedge clk);
      total++; if (start !== 1'b0) $display("FAIL b2b_release%0d: got %b exp 0", blk, start); else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    bit seen;
    do_reset();
    do_cfg(2'b00, 1'b1);
    for (int i = 0; i < 4; i++) send_word(1'b0, 3'(i), 32'h3000_0000 + i);
    for (int i = 0; i < 2; i++) send_word(1'b1, 3'(i), 32'h4000_0000 + i);
    exp_wr.delete();
    #2 rst = 1'b1;
    #1;
    total++; if ({in_ready, d_k, data_we, key_we, start, count_io} !== 9'd0)
      $display("FAIL rmid_ctl: got %b exp 0", {in_ready, d_k, data_we, key_we, start, count_io}); else passed++;
    total++; if ({key_ld_wait, data_ld_wait, aes_mode, e_d, waddr} !== 8'b1100_0000)
      $display("FAIL rmid_regs: got %b exp 11000000", {key_ld_wait, data_ld_wait, aes_mode, e_d, waddr}); else passed++;
    tick();
    rst = 1'b0;
    tick();
    wb = obs_wr.size();
    seen = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    total++; if (seen !== 1'b0) $display("FAIL rmid_no_cfg: in_ready seen %b exp 0", seen); else passed++;
    do_cfg(2'b01, 1'b0);
    for (int i = 0; i < 4; i++) send_word(1'b0, 3'(i), 32'h5000_0000 + i);
    @(negedge clk); tick(); @(negedge clk);
    total++; if ({key_ld_wait, aes_mode, d_k} !== 4'b0011)
      $display("FAIL rmid_restart: got %b exp 0011", {key_ld_wait, aes_mode, d_k}); else passed++;
    tick();
    total++; if (obs_wr.size() - wb != exp_wr.size())
      $display("FAIL rmid_wr_count: got %0d exp %0d", obs_wr.size() - wb, exp_wr.size()); else passed++;
    for (int j = 0; exp_wr.size() > 0; j++) begin
      wr_t e = exp_wr.pop_front();
      total++; if (obs_wr[wb+j] !== e) $display("FAIL rmid_wr%0d: got %h exp %h", j, obs_wr[wb+j], e); else passed++;
    end
  endtask

  task automatic test_done_during_load();
    int wb, rb;
    do_reset();
    wb = obs_wr.size();
    rb = n_re;
    do_cfg(2'b00, 1'b0);
    for (int i = 0; i < 4; i++) send_word(1'b0, 3'(i), 32'h6000_0000 + i);
    for (int i = 0; i < 2; i++) send_word(1'b1, 3'(i), 32'h7000_0000 + i);
    data_done = 1'b1;
    tick();
    data_done = 1'b0;
    for (int i = 2; i < 4; i++) send_word(1'b1, 3'(i), 32'h7000_0000 + i);
    tick();
    cfg_valid = 1'b1; cfg_mode = 2'b11; cfg_e_d = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_e_d = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++; if ({start, data_ld_wait, count_io} !== 6'b10_0100)
      $display("FAIL ddl_start: got %b exp 100100", {start, data_ld_wait, count_io}); else passed++;
    total++; if ({aes_mode, e_d} !== 3'b000) $display("FAIL ddl_cfg_ignored: got %b exp 000", {aes_mode, e_d}); else passed++;
    total++; if (n_re - rb != 0) $display("FAIL ddl_no_read: got %0d reads exp 0", n_re - rb); else passed++;
    tick();
    total++; if (obs_wr.size() - wb != exp_wr.size())
      $display("FAIL ddl_wr_count: got %0d exp %0d", obs_wr.size() - wb, exp_wr.size()); else passed++;
    for (int j = 0; exp_wr.size() > 0; j++) begin
      wr_t e = exp_wr.pop_front();
      total++; if (obs_wr[wb+j] !== e) $display("FAIL ddl_wr%0d: got %h exp %h", j, obs_wr[wb+j], e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_readout_stall();
    test_mode11_toggle();
    test_back_to_back();
    test_reset_mid();
    test_done_during_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
